// File: rtl/modexp.sv
// Left-to-right binary modular exponentiation r = m^e mod n.
// Drives an external modmul through the mm_* port group and consumes every product it returns.
module modexp #(
  parameter int W          = 2048,
  parameter int E          = 2048,
  parameter int CONST_TIME = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [W-1:0] m,
  input  logic [E-1:0] e,
  input  logic [W-1:0] n,
  output logic [W-1:0] r,
  output logic         done,
  output logic         err,
  output logic         mm_start,
  input  logic         mm_ready,
  output logic [W-1:0] mm_a,
  output logic [W-1:0] mm_b,
  output logic [W-1:0] mm_n,
  input  logic [W-1:0] mm_p
);

  localparam int IW = (E > 1) ? $clog2(E) : 1;
  localparam logic [W-1:0]  ONE   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  TWO   = {{(W-2){1'b0}}, 2'b10};
  localparam logic [IW-1:0] I_TOP = IW'(E - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SQ_ISSUE  = 3'd1,
    SQ_WAIT   = 3'd2,
    MUL_ISSUE = 3'd3,
    MUL_WAIT  = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t        state_r;
  logic [W-1:0]  m_r;
  logic [E-1:0]  e_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  acc_r;
  logic [IW-1:0] idx_r;
  logic          busy_seen_r;

  logic          bit_s;
  logic          bad_s;
  logic          want_mul_s;
  logic          sq_cap_s;
  logic          mul_cap_s;
  logic [W-1:0]  cap_val_s;

  assign mm_n = n_r;

  // Capture qualification: a product is taken only once modmul has been seen busy and is ready again
  always_comb begin
    bit_s      = e_r[idx_r];
    bad_s      = (n < TWO) || (m >= n);
    want_mul_s = bit_s || (CONST_TIME != 0);
    if (mm_ready && busy_seen_r) begin
      sq_cap_s  = (state_r == SQ_WAIT);
      mul_cap_s = (state_r == MUL_WAIT);
    end else begin
      sq_cap_s  = 1'b0;
      mul_cap_s = 1'b0;
    end
    if (mul_cap_s && !bit_s) begin
      cap_val_s = acc_r;
    end else begin
      cap_val_s = mm_p;
    end
  end

  // Control FSM with registered outputs and operand/accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ready       <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      mm_start    <= 1'b0;
      r           <= '0;
      m_r         <= '0;
      e_r         <= '0;
      n_r         <= '0;
      acc_r       <= '0;
      idx_r       <= '0;
      busy_seen_r <= 1'b0;
      mm_a        <= '0;
      mm_b        <= '0;
    end else begin
      done     <= 1'b0;
      mm_start <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            ready <= 1'b0;
            if (bad_s) begin
              r       <= '0;
              err     <= 1'b1;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              m_r      <= m;
              e_r      <= e;
              n_r      <= n;
              acc_r    <= ONE;
              idx_r    <= I_TOP;
              err      <= 1'b0;
              mm_a     <= ONE;
              mm_b     <= ONE;
              mm_start <= 1'b1;
              state_r  <= SQ_ISSUE;
            end
          end
        end
        SQ_ISSUE, MUL_ISSUE: begin
          busy_seen_r <= 1'b0;
          state_r     <= (state_r == SQ_ISSUE) ? SQ_WAIT : MUL_WAIT;
        end
        SQ_WAIT, MUL_WAIT: begin
          if (!mm_ready) begin
            busy_seen_r <= 1'b1;
          end else if (sq_cap_s && want_mul_s) begin
            acc_r    <= cap_val_s;
            mm_a     <= cap_val_s;
            mm_b     <= m_r;
            mm_start <= 1'b1;
            state_r  <= MUL_ISSUE;
          end else if (sq_cap_s || mul_cap_s) begin
            // Advance to the next exponent bit, or finish after bit 0
            acc_r <= cap_val_s;
            if (idx_r == '0) begin
              r       <= cap_val_s;
              done    <= 1'b1;
              state_r <= DONE;
            end else begin
              idx_r    <= idx_r - IW'(1);
              mm_a     <= cap_val_s;
              mm_b     <= cap_val_s;
              mm_start <= 1'b1;
              state_r  <= SQ_ISSUE;
            end
          end
        end
        DONE: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          ready   <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
